dcache_ctrl: RTL and testbench

//  Direct-mapped, write-back data cache placed directly downstream of the ALU. The ALU RESULT is the load/store ADDRESS.

---
 rtl/dcache_ctrl_pkg.sv | 35 +++
 rtl/dcache_ctrl_stats.sv | 31 +++
 rtl/dcache_ctrl.sv | 158 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Optional statistics counters are enabled with the DCACHE_STATS_EN macro.
package dcache_ctrl_pkg;

    localparam int NUM_BLOCKS  = 8;
    localparam int BLOCK_BYTES = 4;
    localparam int ADDR_W      = 8;
    localparam int REG_SIZE    = 8;

    localparam int INDEX_W    = $clog2(NUM_BLOCKS);
    localparam int OFFSET_W   = $clog2(BLOCK_BYTES);
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINE_W     = BLOCK_BYTES * REG_SIZE;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        DC_IDLE      = 2'd0,
        DC_WRITEBACK = 2'd1,
        DC_FETCH     = 2'd2
    } dc_state_e;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } dc_addr_t;

    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    // Saturating increment used by the statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == STAT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dcache_ctrl_stats.sv
// Saturating hit/miss counters for dcache_ctrl; only built when DCACHE_STATS_EN is defined.
`ifdef DCACHE_STATS_EN
module dcache_stats
    import dcache_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        i_hit_inc,
    input  logic        i_miss_inc,
    output logic [15:0] o_hit_count,
    output logic [15:0] o_miss_count
);

    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (i_hit_inc)  r_hit_count  <= sat_inc(r_hit_count);
            if (i_miss_inc) r_miss_count <= sat_inc(r_miss_count);
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;

endmodule
`endif

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache: byte loads/stores on hit, block write-back/fetch on miss.
// Define DCACHE_STATS_EN to add HIT_COUNT/MISS_COUNT outputs backed by dcache_stats.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_W-1:0]     ADDRESS,
    input  logic [REG_SIZE-1:0]   WRITEDATA,
    output logic [REG_SIZE-1:0]   READDATA,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
    output logic [LINE_W-1:0]     MEM_WRITEDATA,
    input  logic [LINE_W-1:0]     MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]           HIT_COUNT,
    output logic [15:0]           MISS_COUNT
`endif
);

    // Line storage is deliberately left unreset; only valid/dirty are cleared.
    logic [LINE_W-1:0]     r_data      [NUM_BLOCKS];
    logic [TAG_W-1:0]      r_tag_store [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] r_valid;
    logic [NUM_BLOCKS-1:0] r_dirty;

    dc_state_e             r_state;
    logic [TAG_W-1:0]      r_miss_tag;
    logic [INDEX_W-1:0]    r_miss_index;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [MEM_ADDR_W-1:0] r_mem_address;

    dc_addr_t              w_addr;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_idle_hit;
    logic                  w_write_hit;
    logic                  w_miss_start;
    logic                  w_fill_done;
    logic [LINE_W-1:0]     w_line;
    logic [REG_SIZE-1:0]   w_line_bytes [BLOCK_BYTES];

    assign w_addr       = ADDRESS;
    assign w_req        = READ | WRITE;
    assign w_hit        = r_valid[w_addr.index] && (r_tag_store[w_addr.index] == w_addr.tag);
    assign w_idle_hit   = (r_state == DC_IDLE) && w_req && w_hit;
    assign w_write_hit  = w_idle_hit && WRITE;
    assign w_miss_start = (r_state == DC_IDLE) && w_req && !w_hit;
    assign w_fill_done  = (r_state == DC_FETCH) && !MEM_BUSYWAIT;
    assign w_line       = r_data[w_addr.index];

    generate
        for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : gen_bytes
            assign w_line_bytes[gi] = w_line[gi*REG_SIZE +: REG_SIZE];
        end
    endgenerate

    assign READDATA      = w_hit ? w_line_bytes[w_addr.offset] : '0;
    assign BUSYWAIT      = (r_state != DC_IDLE) || w_miss_start;
    assign MEM_READ      = r_mem_read;
    assign MEM_WRITE     = r_mem_write;
    assign MEM_ADDRESS   = r_mem_address;
    assign MEM_WRITEDATA = r_data[r_miss_index];

    // Refill and store-hit never coincide (different states); reset suppresses both.
    always_ff @(posedge CLK) begin
        if (RESET_N) begin
            if (w_fill_done) begin
                r_data[r_miss_index]      <= MEM_READDATA;
                r_tag_store[r_miss_index] <= r_miss_tag;
            end else if (w_write_hit) begin
                r_data[w_addr.index][w_addr.offset*REG_SIZE +: REG_SIZE] <= WRITEDATA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state       <= DC_IDLE;
            r_valid       <= '0;
            r_dirty       <= '0;
            r_miss_tag    <= '0;
            r_miss_index  <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
        end else begin
            case (r_state)
                DC_IDLE: begin
                    if (w_miss_start) begin
                        // Latch the missing address so a dropped request cannot corrupt the refill.
                        r_miss_tag   <= w_addr.tag;
                        r_miss_index <= w_addr.index;
                        if (r_valid[w_addr.index] && r_dirty[w_addr.index]) begin
                            r_state       <= DC_WRITEBACK;
                            r_mem_write   <= 1'b1;
                            r_mem_address <= {r_tag_store[w_addr.index], w_addr.index};
                        end else begin
                            r_state       <= DC_FETCH;
                            r_mem_read    <= 1'b1;
                            r_mem_address <= {w_addr.tag, w_addr.index};
                        end
                    end else if (w_write_hit) begin
                        r_dirty[w_addr.index] <= 1'b1;
                    end
                end
                DC_WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        r_state       <= DC_FETCH;
                        r_mem_write   <= 1'b0;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= {r_miss_tag, r_miss_index};
                    end
                end
                DC_FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        r_state               <= DC_IDLE;
                        r_mem_read            <= 1'b0;
                        r_valid[r_miss_index] <= 1'b1;
                        r_dirty[r_miss_index] <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= DC_IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // The hit that retires a refilled access is accounted as part of its miss.
    logic r_refilled;

    always_ff @(posedge CLK) begin
        if (!RESET_N) r_refilled <= 1'b0;
        else          r_refilled <= w_fill_done;
    end

    dcache_stats u_stats (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .i_hit_inc    (w_idle_hit && !r_refilled),
        .i_miss_inc   (w_miss_start),
        .o_hit_count  (HIT_COUNT),
        .o_miss_count (MISS_COUNT)
    );
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: reference cache/memory model feeding a scoreboard of
// expected load bytes and expected memory transfers. Stats checks compile under DCACHE_STATS_EN.
module tb_dcache_ctrl;

    logic        CLK;
    logic        RESET_N;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;
`endif

    dcache_ctrl dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
        ,
        .HIT_COUNT     (HIT_COUNT),
        .MISS_COUNT    (MISS_COUNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: backing memory plus cache contents as the CPU should see them.
    logic [31:0] mem_m   [64];
    logic [31:0] m_line  [8];
    logic [2:0]  m_tag   [8];
    logic        m_valid [8];
    logic        m_dirty [8];

    typedef struct packed {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] data;
    } mem_tx_t;

    logic [7:0] q_rd  [$];
    mem_tx_t    q_mem [$];

    task automatic clear_model();
        for (int k = 0; k < 8; k++) begin
            m_valid[k] = 1'b0;
            m_dirty[k] = 1'b0;
        end
    endtask

    // kind: 0 = READ, 1 = WRITE, 2 = READ and WRITE together (behaves as a store).
    task automatic do_access(input int kind, input logic [7:0] addr, input logic [7:0] wdata,
                             input int lat, input string name);
        logic [2:0] t;
        logic [2:0] i;
        logic [1:0] o;
        logic       miss;
        logic [7:0] exp_b;
        mem_tx_t    tx;
        mem_tx_t    cur;
        int         exp_busy;
        int         busy_seen;
        int         held;
        bit         done;
        bit         in_x;
        t = addr[7:5];
        i = addr[4:2];
        o = addr[1:0];
        miss = !(m_valid[i] && m_tag[i] == t);
        exp_busy = 0;
        cur = '0;
        if (miss) begin
            exp_busy = 2 + lat;
            if (m_valid[i] && m_dirty[i]) begin
                tx.we = 1'b1; tx.addr = {m_tag[i], i}; tx.data = m_line[i];
                q_mem.push_back(tx);
                mem_m[{m_tag[i], i}] = m_line[i];
                exp_busy += lat + 1;
            end
            tx.we = 1'b0; tx.addr = {t, i}; tx.data = mem_m[{t, i}];
            q_mem.push_back(tx);
            m_line[i]  = mem_m[{t, i}];
            m_tag[i]   = t;
            m_valid[i] = 1'b1;
            m_dirty[i] = 1'b0;
        end
        if (kind == 0) begin
            q_rd.push_back(m_line[i][o*8 +: 8]);
        end else begin
            m_line[i][o*8 +: 8] = wdata;
            m_dirty[i] = 1'b1;
        end

        READ      = (kind != 1);
        WRITE     = (kind != 0);
        ADDRESS   = addr;
        WRITEDATA = wdata;
        busy_seen = 0;
        held      = 0;
        done      = 0;
        in_x      = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            #1;
            if (BUSYWAIT === 1'b0) begin
                done = 1;
                n_total++;
                if (busy_seen != exp_busy || q_mem.size() != 0) begin
                    n_bad++;
                    $display("FAIL %s stall: got %0d cycles (%0d transfers left) want %0d cycles",
                             name, busy_seen, q_mem.size(), exp_busy);
                end
                n_total++;
                if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s mem_idle: got rd=%b wr=%b want 0 0", name, MEM_READ, MEM_WRITE);
                end
                if (kind == 0) begin
                    exp_b = q_rd.pop_front();
                    n_total++;
                    if (READDATA !== exp_b) begin
                        n_bad++;
                        $display("FAIL %s readdata: got %h want %h", name, READDATA, exp_b);
                    end
                end
            end else begin
                busy_seen++;
                if (MEM_READ === 1'b1 || MEM_WRITE === 1'b1) begin
                    if (!in_x) begin
                        n_total++;
                        if (q_mem.size() == 0) begin
                            n_bad++;
                            $display("FAIL %s unexpected_xfer: got rd=%b wr=%b addr=%h want none",
                                     name, MEM_READ, MEM_WRITE, MEM_ADDRESS);
                            cur.we = MEM_WRITE; cur.addr = MEM_ADDRESS; cur.data = '0;
                        end else begin
                            cur = q_mem.pop_front();
                            if (MEM_WRITE !== cur.we || MEM_READ !== !cur.we || MEM_ADDRESS !== cur.addr) begin
                                n_bad++;
                                $display("FAIL %s xfer: got wr=%b rd=%b addr=%h want wr=%b addr=%h",
                                         name, MEM_WRITE, MEM_READ, MEM_ADDRESS, cur.we, cur.addr);
                            end
                            if (cur.we) begin
                                n_total++;
                                if (MEM_WRITEDATA !== cur.data) begin
                                    n_bad++;
                                    $display("FAIL %s wb_data: got %h want %h", name, MEM_WRITEDATA, cur.data);
                                end
                            end
                        end
                        in_x = 1;
                        held = 0;
                    end
                    if (held == lat) begin
                        MEM_BUSYWAIT = 1'b0;
                        MEM_READDATA = cur.data;
                        in_x = 0;
                    end else begin
                        held++;
                    end
                end
            end
            @(negedge CLK);
            MEM_BUSYWAIT = 1'b1;
        end
        if (!done) begin
            n_total++;
            n_bad++;
            $display("FAIL %s timeout: got BUSYWAIT=%b want 0 within 400 cycles", name, BUSYWAIT);
        end
        READ  = 1'b0;
        WRITE = 1'b0;
        $display("txn %-10s kind=%0d addr=%h wdata=%h lat=%0d miss=%0d stall=%0d",
                 name, kind, addr, wdata, lat, miss, busy_seen);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        n_total++;
        if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0 || READDATA !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b rd=%b wr=%b data=%h want 0 0 0 00",
                     BUSYWAIT, MEM_READ, MEM_WRITE, READDATA);
        end
`ifdef DCACHE_STATS_EN
        n_total++;
        if (HIT_COUNT !== 16'd0 || MISS_COUNT !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_stats: got hit=%0d miss=%0d want 0 0", HIT_COUNT, MISS_COUNT);
        end
`endif
        RESET_N = 1'b1;
        clear_model();
        @(negedge CLK);
        $display("txn reset      done");
    endtask

    task automatic test_refill_read();
        do_access(0, 8'h00, 8'h00, 0, "refill_rd");
    endtask

    task automatic test_read_hit();
        do_access(0, 8'h03, 8'h00, 0, "hit_rd");
    endtask

    task automatic test_write_evict();
        do_access(1, 8'h01, 8'hAA, 0, "hit_wr");
        do_access(0, 8'h21, 8'h00, 1, "evict_rd");
`ifdef DCACHE_STATS_EN
        #1;
        n_total++;
        if (HIT_COUNT !== 16'd2 || MISS_COUNT !== 16'd2) begin
            n_bad++;
            $display("FAIL stats_count: got hit=%0d miss=%0d want 2 2", HIT_COUNT, MISS_COUNT);
        end
`endif
    endtask

    task automatic test_fetch_stall();
        do_access(0, 8'h41, 8'h00, 5, "fetch_stall");
    endtask

    task automatic test_reset_mid_wb();
        do_access(1, 8'h42, 8'h5A, 0, "dirty_wr");
        READ    = 1'b1;
        ADDRESS = 8'h02;
        #1;
        n_total++;
        if (BUSYWAIT !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_wb_miss: got busy=%b want 1", BUSYWAIT);
        end
        @(negedge CLK);
        #1;
        n_total++;
        if (MEM_WRITE !== 1'b1 || MEM_ADDRESS !== 6'h10) begin
            n_bad++;
            $display("FAIL rst_wb_start: got wr=%b addr=%h want 1 10", MEM_WRITE, MEM_ADDRESS);
        end
        RESET_N = 1'b0;
        READ    = 1'b0;
        @(negedge CLK);
        #1;
        n_total++;
        if (MEM_WRITE !== 1'b0 || MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_wb_abort: got wr=%b rd=%b busy=%b want 0 0 0", MEM_WRITE, MEM_READ, BUSYWAIT);
        end
        RESET_N = 1'b1;
        clear_model();
        @(negedge CLK);
        do_access(0, 8'h00, 8'h00, 1, "post_rst");
    endtask

    task automatic test_both_req();
        do_access(2, 8'h07, 8'h3C, 0, "rd_wr_both");
        do_access(0, 8'h07, 8'h00, 0, "both_chk");
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] d;
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom_range(0, 63));
            d = 8'($urandom_range(0, 255));
            do_access(int'($urandom_range(0, 2)), a, d, int'($urandom_range(0, 2)), "b2b");
        end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats_saturate();
        do_access(0, 8'h00, 8'h00, 0, "sat_prime");
        READ    = 1'b1;
        ADDRESS = 8'h00;
        repeat (65540) @(negedge CLK);
        #1;
        READ = 1'b0;
        n_total++;
        if (HIT_COUNT !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL stats_saturate: got %h want ffff", HIT_COUNT);
        end
        @(negedge CLK);
    endtask
`endif

    initial begin
        READ         = 1'b0;
        WRITE        = 1'b0;
        ADDRESS      = 8'h00;
        WRITEDATA    = 8'h00;
        MEM_READDATA = 32'h0;
        MEM_BUSYWAIT = 1'b1;
        RESET_N      = 1'b1;
        for (int k = 0; k < 64; k++) mem_m[k] = $urandom;
        mem_m[0] = 32'h44332211;
        mem_m[8] = 32'h88776655;
        @(negedge CLK);
        test_reset();
        test_refill_read();
        test_read_hit();
        test_write_evict();
        test_fetch_stall();
        test_reset_mid_wb();
        test_both_req();
        test_back_to_back();
`ifdef DCACHE_STATS_EN
        test_stats_saturate();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
